// File: rtl/spi_master_link_pkg.sv
// Shared definitions for the SPI master link and its enc/dec subnode:
// FSM encoding and the message/key/slot width derivations.
package spi_master_link_pkg;

  localparam int unsigned WordW = 32;

  typedef enum logic [2:0] {
    StIdle,
    StArm,
    StCsSetup,
    StShiftIn,
    StSettle,
    StShiftOut,
    StCsHold,
    StDone
  } state_e;

  function automatic int unsigned msg_width(input int unsigned nb);
    return WordW * nb;
  endfunction

  function automatic int unsigned key_width(input int unsigned nk);
    return WordW * nk;
  endfunction

  // Bit slots clocked into the subnode before readout: message then key.
  function automatic int unsigned in_slots(input int unsigned nb, input int unsigned nk);
    return msg_width(nb) + key_width(nk);
  endfunction

endpackage

// File: rtl/spi_master_link_if.sv
// Serial link between the master and one enc/dec subnode.
interface spi_master_link_if;

  logic cs;
  logic sclk;
  logic to_sub_sdi;
  logic sub_rst;
  logic from_sub_sdo;

  modport master (
    output cs,
    output sclk,
    output to_sub_sdi,
    output sub_rst,
    input  from_sub_sdo
  );

  modport slave (
    input  cs,
    input  sclk,
    input  to_sub_sdi,
    input  sub_rst,
    output from_sub_sdo
  );

endinterface

// File: rtl/spi_bit_phase.sv
// Two-cycle sclk slot generator: high phase then low phase while enabled,
// idles high otherwise; slot_end_o marks the last cycle of each slot.
module spi_bit_phase (
  input  logic in_clk,
  input  logic rst,
  input  logic en_i,
  output logic sclk_o,
  output logic slot_end_o
);

  logic sclk_q, sclk_d;

  always_comb begin
    sclk_d = en_i ? ~sclk_q : 1'b1;
  end

  always_ff @(posedge in_clk) begin
    if (rst) begin
      sclk_q <= 1'b1;
    end else begin
      sclk_q <= sclk_d;
    end
  end

  assign sclk_o     = sclk_q;
  assign slot_end_o = en_i & ~sclk_q;

endmodule

// File: rtl/spi_master_link.sv
// Upstream SPI master: shifts message then key into the subnode, waits for
// the enc/dec core to settle, then clocks the result back, all MSB first.
module spi_master_link
  import spi_master_link_pkg::*;
#(
  parameter int unsigned nk     = 8,
  parameter int unsigned nb     = 4,
  parameter int unsigned nr     = 14,
  parameter int unsigned SETTLE = 16
) (
  input  logic                    in_clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [WordW*nb-1:0]     msg_in,
  input  logic [WordW*nk-1:0]     key_in,
  spi_master_link_if.master       spi,
  output logic [WordW*nb-1:0]     result,
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned MW    = msg_width(nb);
  localparam int unsigned TW    = in_slots(nb, nk);
  localparam int unsigned SlotW = $clog2(TW + 1);
  localparam int unsigned SetW  = $clog2(SETTLE + 1);

  localparam logic [SlotW-1:0] InLast  = SlotW'(TW - 1);
  localparam logic [SlotW-1:0] OutLast = SlotW'(MW - 1);
  localparam logic [SetW-1:0]  SetLast = SetW'(SETTLE - 1);

  if (SETTLE < 1 || nr == 0) begin : g_param_check
    $error("spi_master_link: SETTLE must be at least 1 and nr nonzero");
  end

  state_e            state_q, state_d;
  logic [TW-1:0]     tx_q, tx_d;
  logic [MW-1:0]     rx_q, rx_d;
  logic [MW-1:0]     result_q, result_d;
  logic [SlotW-1:0]  slot_q, slot_d;
  logic [SetW-1:0]   settle_q, settle_d;
  logic              cs_q, cs_d;
  logic              sdi_q, sdi_d;
  logic              sub_rst_q, sub_rst_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic shift_en;
  logic sclk;
  logic slot_end;

  assign shift_en = (state_q == StShiftIn) || (state_q == StShiftOut);

  spi_bit_phase u_bit_phase (
    .in_clk     (in_clk),
    .rst        (rst),
    .en_i       (shift_en),
    .sclk_o     (sclk),
    .slot_end_o (slot_end)
  );

  always_comb begin
    state_d  = state_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    result_d = result_q;
    slot_d   = slot_q;
    settle_d = settle_q;

    case (state_q)
      StIdle: begin
        if (start) begin
          tx_d    = {msg_in, key_in};
          state_d = StArm;
        end
      end
      StArm:     state_d = StCsSetup;
      StCsSetup: state_d = StShiftIn;
      StShiftIn: begin
        if (slot_end) begin
          tx_d = tx_q << 1;
          if (slot_q == InLast) begin
            slot_d  = '0;
            state_d = StSettle;
          end else begin
            slot_d = slot_q + 1'b1;
          end
        end
      end
      StSettle: begin
        if (settle_q == SetLast) begin
          settle_d = '0;
          state_d  = StShiftOut;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      StShiftOut: begin
        // Subnode drives each bit on the falling edge; take it as the slot closes.
        if (slot_end) begin
          rx_d = {rx_q[MW-2:0], spi.from_sub_sdo};
          if (slot_q == OutLast) begin
            slot_d  = '0;
            state_d = StCsHold;
          end else begin
            slot_d = slot_q + 1'b1;
          end
        end
      end
      StCsHold: begin
        result_d = rx_q;
        state_d  = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Pin outputs are registered from the next state so they change with it.
    cs_d      = !(state_d inside {StCsSetup, StShiftIn, StSettle, StShiftOut, StCsHold});
    sdi_d     = (state_d == StCsSetup || state_d == StShiftIn) ? tx_d[TW-1] : 1'b0;
    sub_rst_d = (state_d == StArm);
    busy_d    = !(state_d inside {StIdle, StDone});
    done_d    = (state_d == StDone);
  end

  always_ff @(posedge in_clk) begin
    if (rst) begin
      state_q   <= StIdle;
      tx_q      <= '0;
      rx_q      <= '0;
      result_q  <= '0;
      slot_q    <= '0;
      settle_q  <= '0;
      cs_q      <= 1'b1;
      sdi_q     <= 1'b0;
      sub_rst_q <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      result_q  <= result_d;
      slot_q    <= slot_d;
      settle_q  <= settle_d;
      cs_q      <= cs_d;
      sdi_q     <= sdi_d;
      sub_rst_q <= sub_rst_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign spi.cs         = cs_q;
  assign spi.sclk       = sclk;
  assign spi.to_sub_sdi = sdi_q;
  assign spi.sub_rst    = sub_rst_q;
  assign result         = result_q;
  assign busy           = busy_q;
  assign done           = done_q;

endmodule
